mdu_iterative: RTL and testbench

Iterative RV32M multiply/divide unit sitting directly downstream of the single-cycle decode/execute datapath. It accepts `funct7=0000001` R-type operations, with operands taken from the register file read ports, through a valid/ready handshake. It computes the result over multiple cycles with a shared 32-step shift/add–subtract engine, then returns the result and destination tag for register write-back. The unit replaces the datapath's combinational `*`, `/` and `%` operators.

---
 rtl/mdu_iterative_if.sv | 45 ++++
 rtl/mdu_iterative.sv | 184 ++++++++++++++++++
 tb/tb_mdu_iterative.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the execute stage and the
// iterative multiply/divide unit.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            MD_in_valid;
  logic            MD_in_ready;
  logic [2:0]      MD_funct3;
  logic [XLEN-1:0] MD_rs1_data;
  logic [XLEN-1:0] MD_rs2_data;
  logic [4:0]      MD_rd;
  logic            MD_flush;
  logic            MD_out_valid;
  logic            MD_out_ready;
  logic [XLEN-1:0] MD_result;
  logic [4:0]      MD_out_rd;

  modport slave (
    input  MD_in_valid,
    input  MD_funct3,
    input  MD_rs1_data,
    input  MD_rs2_data,
    input  MD_rd,
    input  MD_flush,
    input  MD_out_ready,
    output MD_in_ready,
    output MD_out_valid,
    output MD_result,
    output MD_out_rd
  );

  modport master (
    output MD_in_valid,
    output MD_funct3,
    output MD_rs1_data,
    output MD_rs2_data,
    output MD_rd,
    output MD_flush,
    output MD_out_ready,
    input  MD_in_ready,
    input  MD_out_valid,
    input  MD_result,
    input  MD_out_rd
  );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply and
// restoring divide on sign-stripped magnitudes, sign fix-up at the end.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic          SYS_clk,
  input  logic          SYS_reset,
  mdu_iterative_if.slave md
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN:0]     r_rem;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_out_rd;
  logic              r_out_valid;

  logic              w_fire;
  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN:0]     w_sum;
  logic [XLEN+1:0]   w_rsh;
  logic              w_ge;
  logic [XLEN:0]     w_sub;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_res;

  assign w_fire  = md.MD_in_valid & (r_state == S_IDLE)
                 & ~md.MD_flush;

  // mulhsu signs only rs1; plain mul works on raw bits
  assign w_sgn_a = (md.MD_funct3 == 3'b001)
                 | (md.MD_funct3 == 3'b010)
                 | (md.MD_funct3 == 3'b100)
                 | (md.MD_funct3 == 3'b110);
  assign w_sgn_b = (md.MD_funct3 == 3'b001)
                 | (md.MD_funct3 == 3'b100)
                 | (md.MD_funct3 == 3'b110);

  assign w_sa    = w_sgn_a & md.MD_rs1_data[XLEN-1];
  assign w_sb    = w_sgn_b & md.MD_rs2_data[XLEN-1];
  assign w_abs_a = w_sa ? -md.MD_rs1_data : md.MD_rs1_data;
  assign w_abs_b = w_sb ? -md.MD_rs2_data : md.MD_rs2_data;

  assign w_div0  = md.MD_funct3[2] & (md.MD_rs2_data == '0);
  assign w_ovf   = md.MD_funct3[2] & ~md.MD_funct3[0]
                 & (md.MD_rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                 & (md.MD_rs2_data == '1);

  assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
               + (r_acc[0] ? {1'b0, r_a} : '0);

  // partial remainder never exceeds 33 bits, so the top bit only guards
  assign w_rsh = {r_rem, r_quo[XLEN-1]};
  assign w_ge  = w_rsh >= {2'b00, r_b};
  assign w_sub = w_rsh[XLEN:0] - {1'b0, r_b};

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_q    = (r_sa ^ r_sb) ? -r_quo : r_quo;
  assign w_r    = r_sa ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    w_res = w_q;
    unique case (1'b1)
      (r_f3 == 3'b000):
        w_res = w_prod[XLEN-1:0];
      (~r_f3[2] & (r_f3[1:0] != 2'b00)):
        w_res = w_prod[2*XLEN-1:XLEN];
      (r_f3[2] & ~r_f3[1]):
        w_res = w_q;
      (r_f3[2] & r_f3[1]):
        w_res = w_r;
      default:
        w_res = w_q;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_rd        <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_rd    <= '0;
      r_out_valid <= 1'b0;
    end else if (md.MD_flush) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_f3  <= md.MD_funct3;
            r_rd  <= md.MD_rd;
            r_cnt <= '0;
            r_a   <= w_abs_a;
            r_b   <= w_abs_b;
            r_acc <= {{XLEN{1'b0}}, w_abs_b};
            r_quo <= w_abs_a;
            r_rem <= '0;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_state <= S_CALC;
            // special results are final values: no sign fix-up
            if (w_div0) begin
              r_quo   <= '1;
              r_rem   <= {1'b0, md.MD_rs1_data};
              r_sa    <= 1'b0;
              r_sb    <= 1'b0;
              r_state <= S_FIX;
            end else if (w_ovf) begin
              r_quo   <= {1'b1, {(XLEN-1){1'b0}}};
              r_rem   <= '0;
              r_sa    <= 1'b0;
              r_sb    <= 1'b0;
              r_state <= S_FIX;
            end
          end
        end
        S_CALC: begin
          if (r_f3[2]) begin
            r_quo <= {r_quo[XLEN-2:0], w_ge};
            r_rem <= w_ge ? w_sub : w_rsh[XLEN:0];
          end else begin
            r_acc <= {w_sum, r_acc[XLEN-1:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result    <= w_res;
          r_out_rd    <= r_rd;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (md.MD_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md.MD_in_ready  = (r_state == S_IDLE);
  assign md.MD_out_valid = r_out_valid;
  assign md.MD_result    = r_result;
  assign md.MD_out_rd    = r_out_rd;
endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed RV32M vectors,
// backpressure, flush and mid-operation reset.
module tb_mdu_iterative;
  logic clk;
  logic rst_n;

  mdu_iterative_if #(.XLEN(32)) mif();

  mdu_iterative #(.XLEN(32)) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst_n),
    .md        (mif)
  );

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic [4:0]  rd;
    int          t0;
    int          lat;
  } exp_t;

  typedef struct {
    string       nm;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   t_issue;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every rising MD_out_valid must match the queue head
  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (mif.MD_out_valid === 1'b1 && !pv) begin
        if (sbq.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL unexpected_valid: got result %h, want no output",
                   mif.MD_result);
        end else begin
          e = sbq.pop_front();
          chk({e.nm, "_result"}, mif.MD_result, e.res);
          chk({e.nm, "_rd"}, {27'd0, mif.MD_out_rd}, {27'd0, e.rd});
          chk({e.nm, "_latency"}, cyc - e.t0, e.lat);
        end
      end
      pv = (mif.MD_out_valid === 1'b1);
    end
  end

  task automatic add(input string nm, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res,
                     input int lat);
    vt.push_back('{nm, f3, a, b, rd, res, lat});
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input string nm, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res,
                       input int lat, input bit track);
    int k;
    mif.MD_in_valid = 1'b1;
    mif.MD_funct3   = f3;
    mif.MD_rs1_data = a;
    mif.MD_rs2_data = b;
    mif.MD_rd       = rd;
    k = 0;
    while (mif.MD_in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k = k + 1;
    end
    if (mif.MD_in_ready !== 1'b1) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s_accept: got ready %b want 1", nm, mif.MD_in_ready);
    end else if (track) begin
      sbq.push_back('{nm, res, rd, cyc, lat});
    end
    t_issue = cyc;
    @(negedge clk);
    mif.MD_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((sbq.size() != 0 || mif.MD_in_ready !== 1'b1) && k < 300) begin
      @(negedge clk);
      k = k + 1;
    end
    if (sbq.size() != 0 || mif.MD_in_ready !== 1'b1) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s_timeout: got pending %0d want 0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] hold_res;
    n_cmp = 0;
    n_bad = 0;
    t_issue = 0;
    rst_n = 1'b0;
    mif.MD_in_valid  = 1'b1;
    mif.MD_funct3    = 3'b101;
    mif.MD_rs1_data  = 32'd9;
    mif.MD_rs2_data  = 32'd3;
    mif.MD_rd        = 5'd5;
    mif.MD_flush     = 1'b0;
    mif.MD_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, mif.MD_in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, mif.MD_out_valid}, 32'd0);
    chk("rst_result", mif.MD_result, 32'd0);
    chk("rst_out_rd", {27'd0, mif.MD_out_rd}, 32'd0);
    mif.MD_in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", {31'd0, mif.MD_in_ready}, 32'd1);

    add("mul",      3'b000, 32'h7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34);
    add("mulh",     3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 34);
    add("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 34);
    add("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34);
    add("div",      3'b100, 32'hFFFFFFF9, 32'h2,        5'd5,  32'hFFFFFFFD, 34);
    add("rem",      3'b110, 32'hFFFFFFF9, 32'h2,        5'd6,  32'hFFFFFFFF, 34);
    add("divu",     3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       34);
    add("remu",     3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        34);
    add("divu_z",   3'b101, 32'd5,        32'd0,        5'd12, 32'hFFFFFFFF, 2);
    add("remu_z",   3'b111, 32'd5,        32'd0,        5'd13, 32'd5,        2);
    add("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 2);
    add("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        2);
    add("mulh_neg", 3'b001, 32'hFFFFFFFE, 32'd3,        5'd16, 32'hFFFFFFFF, 34);
    add("rem_z",    3'b110, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFB, 2);
    add("rem_nb",   3'b110, 32'd7,        32'hFFFFFFFE, 5'd18, 32'd1,        34);
    add("div_nb",   3'b100, 32'd7,        32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 34);

    foreach (vt[i]) begin
      issue(vt[i].nm, vt[i].f3, vt[i].a, vt[i].b, vt[i].rd,
            vt[i].res, vt[i].lat, 1'b1);
      wait_idle(vt[i].nm);
    end

    // backpressure: hold result for 10 cycles
    mif.MD_out_ready = 1'b0;
    issue("bp_mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,
          32'hFFFFFFFE, 34, 1'b1);
    k = 0;
    while (mif.MD_out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k = k + 1;
    end
    chk("bp_valid", {31'd0, mif.MD_out_valid}, 32'd1);
    hold_res = 32'hFFFFFFFE;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_result", mif.MD_result, hold_res);
      chk("bp_hold_rd", {27'd0, mif.MD_out_rd}, 32'd9);
      chk("bp_in_ready", {31'd0, mif.MD_in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, mif.MD_out_valid}, 32'd1);
    end
    mif.MD_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", {31'd0, mif.MD_in_ready}, 32'd1);
    chk("bp_valid_drop", {31'd0, mif.MD_out_valid}, 32'd0);
    issue("b2b_divu", 3'b101, 32'd100, 32'd7, 5'd10, 32'd14, 34, 1'b1);
    chk("b2b_busy", {31'd0, mif.MD_in_ready}, 32'd0);
    wait_idle("b2b_divu");

    // flush with the step counter at 15
    issue("fl_divu", 3'b101, 32'd100, 32'd7, 5'd11, 32'd0, 34, 1'b0);
    k = 0;
    while (cyc < t_issue + 16 && k < 50) begin
      @(negedge clk);
      k = k + 1;
    end
    mif.MD_flush = 1'b1;
    @(negedge clk);
    mif.MD_flush = 1'b0;
    chk("flush_idle", {31'd0, mif.MD_in_ready}, 32'd1);
    chk("flush_no_valid", {31'd0, mif.MD_out_valid}, 32'd0);
    repeat (40) @(negedge clk);
    issue("fl_after", 3'b101, 32'd9, 32'd3, 5'd20, 32'd3, 34, 1'b1);
    wait_idle("fl_after");

    // reset in the middle of a multiply
    issue("rs_mul", 3'b000, 32'd1234, 32'd5678, 5'd21, 32'd0, 34, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_idle", {31'd0, mif.MD_in_ready}, 32'd1);
    chk("mrst_no_valid", {31'd0, mif.MD_out_valid}, 32'd0);
    chk("mrst_result", mif.MD_result, 32'd0);
    chk("mrst_out_rd", {27'd0, mif.MD_out_rd}, 32'd0);
    repeat (40) @(negedge clk);
    issue("rs_after", 3'b101, 32'd9, 32'd3, 5'd22, 32'd3, 34, 1'b1);
    wait_idle("rs_after");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
